// File: rtl/im_loader.sv
// im_loader: packs a big-endian byte stream into 32-bit instruction words and
// writes them to consecutive instruction-memory slots from BASE_ADDR upward.
// The fetch PC enable (cpu_en) stays low while a load is running.
// Optional feature macro: IM_LOADER_CHECKSUM_EN adds a 4-byte XOR trailer
// that is compared against the written words and reported on err.
module im_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          DEPTH     = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [12:0] len,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        busy,
  output logic        done,
  output logic        cpu_en,
  output logic        err
);

  localparam logic [12:0] DEPTH_W = 13'(DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
`ifdef IM_LOADER_CHECKSUM_EN
    CHECK = 3'd3,
`endif
    DONE  = 3'd4
  } state_t;

  state_t      state_q;
  logic [12:0] len_q;
  logic [12:0] word_cnt_q;
  logic [1:0]  byte_cnt_q;
  logic [31:0] sr_q;
  logic        in_ready_q;
  logic        im_we_q;
  logic [31:0] im_addr_q;
  logic [31:0] im_wdata_q;
  logic        busy_q;
  logic        done_q;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [31:0] csum_q;
  logic        err_q;
`endif

  logic [12:0] len_d;
  logic [12:0] word_cnt_d;
  logic [31:0] sr_d;
  logic        take;

  // Next-value helpers: clamped length, word counter increment, shifted word
  always_comb begin
    len_d      = (len > DEPTH_W) ? DEPTH_W : len;
    word_cnt_d = word_cnt_q + 13'd1;
    sr_d       = {sr_q[23:0], in_data};
    take       = in_valid && in_ready_q;
  end

  // Loader FSM with registered outputs; a partial word is simply dropped on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      sr_q       <= '0;
      in_ready_q <= 1'b0;
      im_we_q    <= 1'b0;
      im_addr_q  <= BASE_ADDR;
      im_wdata_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      im_we_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            len_q      <= len_d;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            done_q     <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
            err_q      <= 1'b0;
`endif
            if (len_d != 13'd0) begin
              state_q    <= RECV;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        RECV: begin
          if (take) begin
            sr_q       <= sr_d;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              state_q    <= WRITE;
              in_ready_q <= 1'b0;
              im_we_q    <= 1'b1;
              im_addr_q  <= BASE_ADDR + {17'd0, word_cnt_q, 2'b00};
              im_wdata_q <= sr_d;
            end
          end
        end
        WRITE: begin
          word_cnt_q <= word_cnt_d;
`ifdef IM_LOADER_CHECKSUM_EN
          csum_q     <= csum_q ^ sr_q;
`endif
          in_ready_q <= 1'b1;
          if (word_cnt_d == len_q) begin
`ifdef IM_LOADER_CHECKSUM_EN
            state_q    <= CHECK;
`else
            state_q    <= DONE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
`endif
          end else begin
            state_q <= RECV;
          end
        end
`ifdef IM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (take) begin
            sr_q       <= sr_d;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              err_q      <= (sr_d != csum_q);
              state_q    <= DONE;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign im_we    = im_we_q;
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign cpu_en   = ~busy_q;
`ifdef IM_LOADER_CHECKSUM_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: doc/im_loader.md
# im_loader

Instruction-memory loader for the fetch stage: receives a byte stream, packs it big-endian into 32-bit MIPS instruction words, and writes them to consecutive instruction-memory word slots starting at the text base address. It replaces the simulation-only file preload with a run-time write path. It holds the fetch-stage PC enable low while a load is in progress.

## Interface
- `BASE_ADDR`, 32'h00003000: byte address of the first word written.
- `DEPTH`, 4096: instruction-memory capacity in words.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `start` input 1: single-cycle load request; honoured only in IDLE or DONE.
- `len` input 13: word count, sampled on accepted `start`; 0 = no load; values >DEPTH saturate to DEPTH.
- `in_valid` input 1: byte available on `in_data`.
- `in_data` input 8: stream byte, most significant byte of each word first.
- `in_ready` output 1: loader accepts a byte this cycle; a byte is consumed when `in_valid && in_ready`.
- `im_we` output 1: one-cycle write strobe to instruction memory.
- `im_addr` output 32: byte address of the write, `BASE_ADDR + 4*word_cnt`.
- `im_wdata` output 32: packed instruction word.
- `busy` output 1: load in progress.
- `done` output 1: sticky, last load completed.
- `cpu_en` output 1: fetch PC enable, `~busy`.
- `err` output 1: checksum mismatch (see Configuration).

## Operation
- States: IDLE, RECV, WRITE, CHECK (macro only), DONE.
- IDLE: `in_ready`=0. Accepted `start`: latch clamped `len`, clear `byte_cnt`, `word_cnt`, checksum, `done`, `err`. Go to RECV if `len`≠0, else DONE.
- RECV: `in_ready`=1. Each consumed byte: `sr <= {sr[23:0], in_data}`, `byte_cnt++` (2 bits, wraps). The 4th byte moves to WRITE.
- WRITE: `im_we`=1, `im_addr`=`BASE_ADDR + {word_cnt,2'b00}`, `im_wdata`=`sr`, `in_ready`=0. Checksum XORs in `sr`. Then `word_cnt++`. If the new count equals `len`, go to CHECK (macro) or DONE; otherwise go to RECV.
- CHECK: same byte-collection as RECV. After the 4th byte, set `err` = (`sr` ≠ checksum) and go to DONE. No memory write occurs.
- DONE: `done`=1, `in_ready`=0. Accepted `start` restarts exactly as from IDLE.
- `start` in RECV/WRITE/CHECK is ignored.
- `busy` = state ∈ {RECV, WRITE, CHECK}.
- `in_valid` low in RECV stalls without side effects; bytes are never dropped or duplicated.

## Timing
- Reset values: state IDLE, `in_ready` 0, `im_we` 0, `im_addr` `BASE_ADDR`, `im_wdata` 0, `busy` 0, `done` 0, `cpu_en` 1, `err` 0.
- All outputs are decoded from registered state/data, with no combinational path from inputs.
- `start` accepted at edge N: `busy`=1 and `in_ready`=1 from cycle N+1.
- 4th byte consumed at edge M: `im_we`=1 during cycle M+1 only; `in_ready` returns at M+2.
- Minimum throughput is 5 cycles per word.
- After the final WRITE (or CHECK completion), `done`=1 and `cpu_en`=1 in the next cycle.
- `im_addr`/`im_wdata` hold their last values outside WRITE.
- Reset mid-load aborts immediately. A partial word is discarded with no write; already-written words are not undone.

## Configuration
- `IM_LOADER_CHECKSUM_EN` defined: after `len` words, a 4-byte trailer equal to the XOR of all written words is received in CHECK. `err` reports a mismatch and is cleared on the next accepted `start`.
- Undefined: CHECK state, checksum register, and trailer are absent. WRITE of the last word goes directly to DONE. `err` is tied to 0.

## Test plan
- Reset then `start`, `len`=2, bytes 3C,01,12,34,00,00,00,00 → writes 0x3C011234@0x3000 and 0x00000000@0x3004; `done`=1; `cpu_en` low only while `busy`.
- `in_valid` toggled every other cycle, `len`=1, bytes AA,BB,CC,DD → single write of 0xAABBCCDD@0x3000; exactly one `im_we` pulse, 1 cycle after the 4th byte.
- `len`=0 → DONE next cycle, no `im_we`; `len`=5000 → exactly 4096 writes, last at 0x6FFC.
- `start` pulsed mid-load and `reset` asserted after 2 of 4 bytes → start ignored; reset clears outputs asynchronously, no write; a fresh load then succeeds.
- Macro on, `len`=2, words 0x11111111, 0x22222222, trailer 0x33333333 → `err`=0; trailer 0x33333334 → `err`=1; both words written in either case.
- DONE then new `start`, `len`=1 → `done` clears, word rewritten at 0x3000 and not appended.
